// File: rtl/spi_conf_rx.sv
// SPI configuration receiver: synchronizes the ARM SPI pins, assembles 16-bit frames
// framed by ncs and decodes them into conf_word / divisor / conf_enio updates.
module spi_conf_rx (
  input  logic       ck_1356meg,
  input  logic       nreset,
  input  logic       spck,
  input  logic       ncs,
  input  logic       mosi,
  output logic [7:0] conf_word,
  output logic [7:0] divisor,
  output logic [7:0] conf_enio,
  output logic       conf_stb,
  output logic       div_stb,
  output logic       enio_stb,
  output logic       frame_err,
  output logic [3:0] err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_JUDGE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  spck_sync, ncs_sync, mosi_sync;
  logic        spck_hist, ncs_hist;
  logic [1:0]  settle;
  logic        ncs_live;
  logic [15:0] shift_reg;
  logic [4:0]  bit_cnt;
  logic        spck_rise, ncs_fall, ncs_rise;

  always_ff @(posedge ck_1356meg or negedge nreset) begin
    if (!nreset) begin
      spck_sync <= 2'b00;
      ncs_sync  <= 2'b11;
      mosi_sync <= 2'b00;
      spck_hist <= 1'b0;
      ncs_hist  <= 1'b1;
    end else begin
      spck_sync <= {spck_sync[0], spck};
      ncs_sync  <= {ncs_sync[0], ncs};
      mosi_sync <= {mosi_sync[0], mosi};
      spck_hist <= spck_sync[1];
      ncs_hist  <= ncs_sync[1];
    end
  end

  // The ncs synchronizer wakes up at 1, so a pin already low at reset release would
  // look like a falling edge; only accept falls once ncs has really been seen high.
  always_ff @(posedge ck_1356meg or negedge nreset) begin
    if (!nreset) begin
      settle   <= 2'b00;
      ncs_live <= 1'b0;
    end else begin
      settle   <= {settle[0], 1'b1};
      ncs_live <= ncs_live | (settle[1] & ncs_sync[1]);
    end
  end

  assign spck_rise = spck_sync[1] & ~spck_hist;
  assign ncs_fall  = ~ncs_sync[1] & ncs_hist & ncs_live;
  assign ncs_rise  = ncs_sync[1] & ~ncs_hist;

  always_ff @(posedge ck_1356meg or negedge nreset) begin
    if (!nreset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ncs_fall) state_d = S_ARMED;
      S_ARMED: if (ncs_rise) state_d = S_JUDGE;
      S_JUDGE: state_d = ncs_fall ? S_ARMED : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ck_1356meg or negedge nreset) begin
    if (!nreset) begin
      shift_reg <= 16'h0000;
      bit_cnt   <= 5'd0;
    end else if (ncs_fall) begin
      bit_cnt <= 5'd0;
    end else if (state_q == S_ARMED && spck_rise && !ncs_sync[1]) begin
      shift_reg <= {shift_reg[14:0], mosi_sync[1]};
      if (bit_cnt != 5'd17) bit_cnt <= bit_cnt + 5'd1;
    end
  end

  // Registers and pulses land one cycle after the ncs rise is seen.
  always_ff @(posedge ck_1356meg or negedge nreset) begin
    if (!nreset) begin
      conf_word <= 8'hE0;
      divisor   <= 8'd0;
      conf_enio <= 8'd0;
      conf_stb  <= 1'b0;
      div_stb   <= 1'b0;
      enio_stb  <= 1'b0;
      frame_err <= 1'b0;
      err_cnt   <= 4'd0;
    end else begin
      conf_stb  <= 1'b0;
      div_stb   <= 1'b0;
      enio_stb  <= 1'b0;
      frame_err <= 1'b0;
      if (state_q == S_JUDGE) begin
        if (bit_cnt == 5'd16) begin
          case (shift_reg[15:12])
            4'b0001: begin conf_word <= shift_reg[7:0]; conf_stb <= 1'b1; end
            4'b0010: begin divisor   <= shift_reg[7:0]; div_stb  <= 1'b1; end
            4'b0100: begin conf_enio <= shift_reg[7:0]; enio_stb <= 1'b1; end
            default: ;
          endcase
        end else begin
          frame_err <= 1'b1;
          if (err_cnt != 4'hF) err_cnt <= err_cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_conf_rx.sv
// Bench for spi_conf_rx: bit-banged SPI frames checked against a frame-level model
// of the three configuration registers and the error counter.
module tb_spi_conf_rx;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       spck = 1'b0;
  logic       ncs = 1'b1;
  logic       mosi = 1'b0;
  logic [7:0] conf_word, divisor, conf_enio;
  logic       conf_stb, div_stb, enio_stb, frame_err;
  logic [3:0] err_cnt;

  int n_checks = 0;
  int n_pass = 0;

  // Frame-level reference state
  logic [7:0] m_conf, m_div, m_enio;
  logic [3:0] m_err;

  spi_conf_rx dut (
    .ck_1356meg(clk), .nreset(nreset), .spck(spck), .ncs(ncs), .mosi(mosi),
    .conf_word(conf_word), .divisor(divisor), .conf_enio(conf_enio),
    .conf_stb(conf_stb), .div_stb(div_stb), .enio_stb(enio_stb),
    .frame_err(frame_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_conf = 8'hE0; m_div = 8'h00; m_enio = 8'h00; m_err = 4'd0;
  endtask

  // ev: 0 none, 1 conf, 2 div, 3 enio, 4 frame error
  task automatic model_frame(input logic [31:0] d, input int n, output int ev);
    logic [15:0] f;
    f = d[15:0];
    ev = 0;
    if (n != 16) begin
      ev = 4;
      if (m_err < 4'd15) m_err = m_err + 4'd1;
    end else if (f[15:12] == 4'd1) begin ev = 1; m_conf = f[7:0]; end
    else if (f[15:12] == 4'd2) begin ev = 2; m_div = f[7:0]; end
    else if (f[15:12] == 4'd4) begin ev = 3; m_enio = f[7:0]; end
  endtask

  task automatic do_reset();
    @(negedge clk);
    nreset = 1'b0; ncs = 1'b1; spck = 1'b0; mosi = 1'b0;
    repeat (3) @(negedge clk);
    nreset = 1'b1;
    repeat (5) @(negedge clk);
    model_reset();
  endtask

  task automatic drop_ncs();
    @(negedge clk);
    ncs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic shift_bits(input logic [31:0] d, input int n, input int ph);
    @(negedge clk);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = d[i];
      repeat (ph) @(negedge clk);
      spck = 1'b1;
      repeat (ph) @(negedge clk);
      spck = 1'b0;
    end
    repeat (2) @(negedge clk);
  endtask

  // Raise ncs and watch the next 8 cycles for strobes; regs_c3 is the register
  // snapshot on the cycle before the update is due.
  task automatic raise_ncs(output int ev, output int cyc, output int pulses,
                           output bit multi, output logic [23:0] regs_c3);
    int k;
    @(negedge clk);
    ncs = 1'b1;
    ev = 0; cyc = 0; pulses = 0; multi = 1'b0; regs_c3 = 24'h0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      k = int'(conf_stb) + int'(div_stb) + int'(enio_stb) + int'(frame_err);
      if (k > 1) multi = 1'b1;
      pulses += k;
      if (c == 3) regs_c3 = {conf_word, divisor, conf_enio};
      if (k > 0 && ev == 0) begin
        cyc = c;
        ev = conf_stb ? 1 : div_stb ? 2 : enio_stb ? 3 : 4;
      end
    end
  endtask

  task automatic send_frame(input logic [31:0] d, input int n, input int ph,
                            output int ev, output int cyc, output int pulses,
                            output bit multi, output logic [23:0] regs_c3);
    drop_ncs();
    shift_bits(d, n, ph);
    raise_ncs(ev, cyc, pulses, multi, regs_c3);
  endtask

  task automatic test_reset();
    int ev, cyc, pulses; bit multi; logic [23:0] r3;
    do_reset();
    n_checks++;
    if ({conf_word, divisor, conf_enio, err_cnt} !== {8'hE0, 8'h00, 8'h00, 4'h0}) begin
      $display("FAIL reset_regs: got %h expected %h", {conf_word, divisor, conf_enio, err_cnt},
               {8'hE0, 8'h00, 8'h00, 4'h0});
    end else n_pass++;
    n_checks++;
    if ({conf_stb, div_stb, enio_stb, frame_err} !== 4'b0000) begin
      $display("FAIL reset_pulses: got %b expected 0000", {conf_stb, div_stb, enio_stb, frame_err});
    end else n_pass++;
    send_frame(32'h1055, 16, 3, ev, cyc, pulses, multi, r3);
    send_frame(32'h1, 3, 3, ev, cyc, pulses, multi, r3);
    @(negedge clk); #2;
    nreset = 1'b0;
    #1;
    n_checks++;
    if ({conf_word, err_cnt} !== {8'hE0, 4'h0}) begin
      $display("FAIL reset_async: got %h expected %h", {conf_word, err_cnt}, {8'hE0, 4'h0});
    end else n_pass++;
    do_reset();
  endtask

  task automatic test_conf();
    int ev, cyc, pulses; bit multi; logic [23:0] r3;
    send_frame(32'h10C3, 16, 4, ev, cyc, pulses, multi, r3);
    n_checks++;
    if (ev !== 1 || cyc !== 4 || pulses !== 1) begin
      $display("FAIL conf_strobe: got ev=%0d cyc=%0d pulses=%0d expected ev=1 cyc=4 pulses=1", ev, cyc, pulses);
    end else n_pass++;
    n_checks++;
    if (r3 !== {8'hE0, 8'h00, 8'h00}) begin
      $display("FAIL conf_early: got %h expected %h", r3, {8'hE0, 8'h00, 8'h00});
    end else n_pass++;
    n_checks++;
    if ({conf_word, divisor, conf_enio} !== {8'hC3, 8'h00, 8'h00}) begin
      $display("FAIL conf_regs: got %h expected %h", {conf_word, divisor, conf_enio}, {8'hC3, 8'h00, 8'h00});
    end else n_pass++;
    do_reset();
  endtask

  task automatic test_div_enio();
    int ev, cyc, pulses; bit multi; logic [23:0] r3;
    send_frame(32'h2059, 16, 3, ev, cyc, pulses, multi, r3);
    n_checks++;
    if (ev !== 2 || cyc !== 4 || pulses !== 1 || divisor !== 8'h59) begin
      $display("FAIL div_update: got ev=%0d cyc=%0d pulses=%0d div=%h expected ev=2 cyc=4 pulses=1 div=59",
               ev, cyc, pulses, divisor);
    end else n_pass++;
    send_frame(32'h4012, 16, 5, ev, cyc, pulses, multi, r3);
    n_checks++;
    if (ev !== 3 || cyc !== 4 || pulses !== 1) begin
      $display("FAIL enio_strobe: got ev=%0d cyc=%0d pulses=%0d expected ev=3 cyc=4 pulses=1", ev, cyc, pulses);
    end else n_pass++;
    n_checks++;
    if ({conf_word, divisor, conf_enio} !== {8'hE0, 8'h59, 8'h12}) begin
      $display("FAIL div_enio_regs: got %h expected %h", {conf_word, divisor, conf_enio}, {8'hE0, 8'h59, 8'h12});
    end else n_pass++;
  endtask

  task automatic test_bad_frames();
    int ev, cyc, pulses, n; bit multi; logic [23:0] r3;
    do_reset();
    send_frame(32'h10C3 >> 1, 15, 3, ev, cyc, pulses, multi, r3);
    n_checks++;
    if (ev !== 4 || cyc !== 4 || pulses !== 1 || err_cnt !== 4'd1) begin
      $display("FAIL err_15bit: got ev=%0d cyc=%0d pulses=%0d cnt=%0d expected ev=4 cyc=4 pulses=1 cnt=1",
               ev, cyc, pulses, err_cnt);
    end else n_pass++;
    send_frame({15'd0, 17'h110C3}, 17, 3, ev, cyc, pulses, multi, r3);
    n_checks++;
    if (ev !== 4 || pulses !== 1 || err_cnt !== 4'd2) begin
      $display("FAIL err_17bit: got ev=%0d pulses=%0d cnt=%0d expected ev=4 pulses=1 cnt=2", ev, pulses, err_cnt);
    end else n_pass++;
    n_checks++;
    if ({conf_word, divisor, conf_enio} !== {8'hE0, 8'h00, 8'h00}) begin
      $display("FAIL err_regs: got %h expected %h", {conf_word, divisor, conf_enio}, {8'hE0, 8'h00, 8'h00});
    end else n_pass++;
    for (int i = 0; i < 20; i++) begin
      n = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 15)) : int'($urandom_range(17, 20));
      send_frame($urandom, n, 3, ev, cyc, pulses, multi, r3);
    end
    n_checks++;
    if (err_cnt !== 4'd15) begin
      $display("FAIL err_saturate: got %0d expected 15", err_cnt);
    end else n_pass++;
  endtask

  task automatic test_unknown_op();
    int ev, cyc, pulses; bit multi; logic [23:0] r3;
    do_reset();
    send_frame(32'h2033, 16, 3, ev, cyc, pulses, multi, r3);
    send_frame(32'h8077, 16, 3, ev, cyc, pulses, multi, r3);
    n_checks++;
    if (pulses !== 0 || {conf_word, divisor, conf_enio, err_cnt} !== {8'hE0, 8'h33, 8'h00, 4'h0}) begin
      $display("FAIL unknown_op: got pulses=%0d regs=%h expected pulses=0 regs=%h", pulses,
               {conf_word, divisor, conf_enio, err_cnt}, {8'hE0, 8'h33, 8'h00, 4'h0});
    end else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int ev, cyc, pulses; bit multi; logic [23:0] r3;
    do_reset();
    drop_ncs();
    shift_bits(32'h10, 8, 3);
    nreset = 1'b0;
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    repeat (4) @(negedge clk);
    shift_bits(32'hAA, 8, 3);
    raise_ncs(ev, cyc, pulses, multi, r3);
    n_checks++;
    if (pulses !== 0 || {conf_word, err_cnt} !== {8'hE0, 4'h0}) begin
      $display("FAIL reset_mid_frame: got pulses=%0d conf=%h cnt=%0d expected pulses=0 conf=e0 cnt=0",
               pulses, conf_word, err_cnt);
    end else n_pass++;
  endtask

  task automatic test_idle_spck_min_phase();
    int ev, cyc, pulses; bit multi; logic [23:0] r3;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      mosi = 1'($urandom_range(0, 1));
      repeat (3) @(negedge clk);
      spck = ~spck;
    end
    spck = 1'b0;
    mosi = 1'b0;
    n_checks++;
    if ({conf_stb, div_stb, enio_stb, frame_err, conf_word} !== {4'b0000, 8'hE0}) begin
      $display("FAIL idle_spck: got %h expected %h", {conf_stb, div_stb, enio_stb, frame_err, conf_word},
               {4'b0000, 8'hE0});
    end else n_pass++;
    send_frame(32'h10FF, 16, 3, ev, cyc, pulses, multi, r3);
    n_checks++;
    if (ev !== 1 || cyc !== 4 || pulses !== 1 || conf_word !== 8'hFF) begin
      $display("FAIL min_phase: got ev=%0d cyc=%0d pulses=%0d conf=%h expected ev=1 cyc=4 pulses=1 conf=ff",
               ev, cyc, pulses, conf_word);
    end else n_pass++;
  endtask

  task automatic test_random();
    int ev, cyc, pulses, n, exp_ev, sel; bit multi; logic [23:0] r3;
    logic [31:0] d;
    logic [3:0] op;
    logic [3:0] op_tab [6];
    op_tab = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd0, 4'd3};
    do_reset();
    for (int i = 0; i < 25; i++) begin
      sel = int'($urandom_range(0, 9));
      n = (sel < 7) ? 16 : (sel == 7) ? 15 : (sel == 8) ? 17 : int'($urandom_range(1, 20));
      op = ($urandom_range(0, 5) == 0) ? 4'($urandom) : op_tab[$urandom_range(0, 5)];
      d = (n == 16) ? {16'h0, op, 12'($urandom)} : $urandom;
      model_frame(d, n, exp_ev);
      send_frame(d, n, int'($urandom_range(3, 5)), ev, cyc, pulses, multi, r3);
      n_checks++;
      if (ev !== exp_ev || multi || pulses !== ((exp_ev != 0) ? 1 : 0) || (exp_ev != 0 && cyc !== 4)) begin
        $display("FAIL rand_event[%0d]: got ev=%0d cyc=%0d pulses=%0d multi=%0d expected ev=%0d cyc=4",
                 i, ev, cyc, pulses, multi, exp_ev);
      end else n_pass++;
      n_checks++;
      if ({conf_word, divisor, conf_enio, err_cnt} !== {m_conf, m_div, m_enio, m_err}) begin
        $display("FAIL rand_regs[%0d]: got %h expected %h", i, {conf_word, divisor, conf_enio, err_cnt},
                 {m_conf, m_div, m_enio, m_err});
      end else n_pass++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_conf();
    test_div_enio();
    test_bad_frames();
    test_unknown_op();
    test_reset_mid_frame();
    test_idle_spck_min_phase();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
